// File: rtl/decode_prefix_collector_pkg.sv
// decode_pkg: shared types and byte constants for the x86 prefix collector.
// Rev 1.0
`default_nettype none

package decode_pkg;

    // 386 segment register encoding
    typedef enum logic [2:0] {
        ES = 3'd0,
        CS = 3'd1,
        SS = 3'd2,
        DS = 3'd3,
        FS = 3'd4,
        GS = 3'd5
    } seg_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        FAULT   = 2'd2
    } state_t;

    localparam int PFX_CNT_W = 4;

    localparam logic [7:0] PFX_ES     = 8'h26;
    localparam logic [7:0] PFX_CS     = 8'h2E;
    localparam logic [7:0] PFX_SS     = 8'h36;
    localparam logic [7:0] PFX_DS     = 8'h3E;
    localparam logic [7:0] PFX_FS     = 8'h64;
    localparam logic [7:0] PFX_GS     = 8'h65;
    localparam logic [7:0] PFX_OPSIZE = 8'h66;
    localparam logic [7:0] PFX_ADSIZE = 8'h67;
    localparam logic [7:0] PFX_LOCK   = 8'hF0;
    localparam logic [7:0] PFX_REPNE  = 8'hF2;
    localparam logic [7:0] PFX_REP    = 8'hF3;

    typedef struct packed {
        logic                 operand;
        logic                 address;
        logic                 lock;
        logic                 rep;
        logic                 repne;
        logic                 seg_valid;
        seg_t                 seg;
        logic [PFX_CNT_W-1:0] count;
    } prefix_set_t;

    localparam prefix_set_t PFX_NONE = '0;

    // One-hot order {gs, fs, ds, ss, cs, es}
    function automatic seg_t seg_encode(input logic [5:0] onehot);
        seg_t s;
        s = ES;
        case (onehot)
            6'b000010: s = CS;
            6'b000100: s = SS;
            6'b001000: s = DS;
            6'b010000: s = FS;
            6'b100000: s = GS;
            default:   s = ES;
        endcase
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_prefix_collector_if.sv
// Byte-in / bundle-out handshake bundle between prefetch queue, collector and decoder.
// Rev 1.0
`default_nettype none

interface decode_prefix_collector_if #(
    parameter int CNT_W = 4
) ();
    import decode_pkg::*;

    logic             flush;
    logic             default_size;
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       out_opcode;
    logic             out_operand_32;
    logic             out_address_32;
    logic             out_lock;
    logic             out_rep;
    logic             out_repne;
    logic             out_seg_valid;
    seg_t             out_seg;
    logic [CNT_W-1:0] out_prefix_count;
    logic             out_valid;
    logic             out_ready;
    logic             fault;

    modport master (
        output flush, default_size, in_byte, in_valid, out_ready,
        input  in_ready, out_opcode, out_operand_32, out_address_32, out_lock,
               out_rep, out_repne, out_seg_valid, out_seg, out_prefix_count,
               out_valid, fault
    );

    modport slave (
        input  flush, default_size, in_byte, in_valid, out_ready,
        output in_ready, out_opcode, out_operand_32, out_address_32, out_lock,
               out_rep, out_repne, out_seg_valid, out_seg, out_prefix_count,
               out_valid, fault
    );

endinterface

`default_nettype wire

// File: rtl/decode_prefix.sv
// decode_prefix: combinational classifier for segment, size and lock prefix bytes.
// Rev 1.0
`default_nettype none

module decode_prefix
    import decode_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       segment_override_es_o,
    output logic       segment_override_cs_o,
    output logic       segment_override_ss_o,
    output logic       segment_override_ds_o,
    output logic       segment_override_fs_o,
    output logic       segment_override_gs_o,
    output logic       operand_size_o,
    output logic       address_size_o,
    output logic       lock_o,
    output logic       prefix_o
);

    always_comb begin
        segment_override_es_o = 1'b0;
        segment_override_cs_o = 1'b0;
        segment_override_ss_o = 1'b0;
        segment_override_ds_o = 1'b0;
        segment_override_fs_o = 1'b0;
        segment_override_gs_o = 1'b0;
        operand_size_o        = 1'b0;
        address_size_o        = 1'b0;
        lock_o                = 1'b0;
        case (byte_i)
            PFX_ES:     segment_override_es_o = 1'b1;
            PFX_CS:     segment_override_cs_o = 1'b1;
            PFX_SS:     segment_override_ss_o = 1'b1;
            PFX_DS:     segment_override_ds_o = 1'b1;
            PFX_FS:     segment_override_fs_o = 1'b1;
            PFX_GS:     segment_override_gs_o = 1'b1;
            PFX_OPSIZE: operand_size_o        = 1'b1;
            PFX_ADSIZE: address_size_o        = 1'b1;
            PFX_LOCK:   lock_o                = 1'b1;
            default:    ;
        endcase
    end

    assign prefix_o = segment_override_es_o | segment_override_cs_o |
                      segment_override_ss_o | segment_override_ds_o |
                      segment_override_fs_o | segment_override_gs_o |
                      operand_size_o | address_size_o | lock_o;

endmodule

`default_nettype wire

// File: rtl/decode_prefix_collector.sv
// decode_prefix_collector: gathers prefix bytes of one instruction and hands the opcode
// plus merged prefix set to the decoder; faults when the 386 prefix limit is exceeded.
// Rev 1.0
`default_nettype none

module decode_prefix_collector
    import decode_pkg::*;
#(
    parameter int MAX_PREFIX = 14,
    parameter int CNT_W      = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    decode_prefix_collector_if.slave   bus
);

    logic w_seg_es, w_seg_cs, w_seg_ss, w_seg_ds, w_seg_fs, w_seg_gs;
    logic w_opsize, w_adsize, w_lock, w_dp_prefix;
    logic w_is_rep, w_is_repne, w_is_prefix, w_accept;
    logic [5:0] w_seg_onehot;

    decode_prefix u_decode_prefix (
        .byte_i                (bus.in_byte),
        .segment_override_es_o (w_seg_es),
        .segment_override_cs_o (w_seg_cs),
        .segment_override_ss_o (w_seg_ss),
        .segment_override_ds_o (w_seg_ds),
        .segment_override_fs_o (w_seg_fs),
        .segment_override_gs_o (w_seg_gs),
        .operand_size_o        (w_opsize),
        .address_size_o        (w_adsize),
        .lock_o                (w_lock),
        .prefix_o              (w_dp_prefix)
    );

    state_t      state_q;
    prefix_set_t acc_q;
    prefix_set_t acc_d;
    prefix_set_t out_q;
    logic [7:0]  opcode_q;
    logic        out_valid_q;
    logic        fault_q;

    assign w_seg_onehot = {w_seg_gs, w_seg_fs, w_seg_ds, w_seg_ss, w_seg_cs, w_seg_es};
    assign w_is_rep     = (bus.in_byte == PFX_REP);
    assign w_is_repne   = (bus.in_byte == PFX_REPNE);
    assign w_is_prefix  = w_dp_prefix | w_is_rep | w_is_repne;

    // Flush wins over everything, so no byte is consumed in the flush cycle.
    assign bus.in_ready = !bus.flush &&
                          ((state_q == COLLECT) || ((state_q == HOLD) && bus.out_ready));
    assign w_accept     = bus.in_valid && bus.in_ready;

    // Accumulator after merging the current byte as a prefix.
    always_comb begin
        acc_d = acc_q;
        if (w_opsize) acc_d.operand = 1'b1;
        if (w_adsize) acc_d.address = 1'b1;
        if (w_lock)   acc_d.lock    = 1'b1;
        if (w_is_rep) begin
            acc_d.rep   = 1'b1;
            acc_d.repne = 1'b0;
        end
        if (w_is_repne) begin
            acc_d.repne = 1'b1;
            acc_d.rep   = 1'b0;
        end
        if (|w_seg_onehot) begin
            acc_d.seg_valid = 1'b1;
            acc_d.seg       = seg_encode(w_seg_onehot);
        end
        acc_d.count = acc_q.count + PFX_CNT_W'(1);
    end

    // Size flags become effective sizes against the descriptor default.
    function automatic prefix_set_t bundle_of(input prefix_set_t acc, input logic dsz);
        prefix_set_t b;
        b         = acc;
        b.operand = acc.operand ^ dsz;
        b.address = acc.address ^ dsz;
        return b;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= COLLECT;
            acc_q       <= PFX_NONE;
            out_q       <= PFX_NONE;
            opcode_q    <= 8'h00;
            out_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else if (bus.flush) begin
            state_q     <= COLLECT;
            acc_q       <= PFX_NONE;
            out_q       <= PFX_NONE;
            opcode_q    <= 8'h00;
            out_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (w_accept) begin
                        if (w_is_prefix) begin
                            if (acc_q.count == PFX_CNT_W'(MAX_PREFIX)) begin
                                state_q <= FAULT;
                                fault_q <= 1'b1;
                                acc_q   <= PFX_NONE;
                            end else begin
                                acc_q <= acc_d;
                            end
                        end else begin
                            opcode_q    <= bus.in_byte;
                            out_q       <= bundle_of(acc_q, bus.default_size);
                            out_valid_q <= 1'b1;
                            acc_q       <= PFX_NONE;
                            state_q     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // acc_q is already clear here; a prefix starts a fresh set.
                    if (bus.out_ready) begin
                        if (w_accept && !w_is_prefix) begin
                            opcode_q <= bus.in_byte;
                            out_q    <= bundle_of(acc_q, bus.default_size);
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= COLLECT;
                            if (w_accept) acc_q <= acc_d;
                        end
                    end
                end
                FAULT:   fault_q <= 1'b1;
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign bus.out_opcode       = opcode_q;
    assign bus.out_operand_32   = out_q.operand;
    assign bus.out_address_32   = out_q.address;
    assign bus.out_lock         = out_q.lock;
    assign bus.out_rep          = out_q.rep;
    assign bus.out_repne        = out_q.repne;
    assign bus.out_seg_valid    = out_q.seg_valid;
    assign bus.out_seg          = out_q.seg;
    assign bus.out_prefix_count = CNT_W'(out_q.count);
    assign bus.out_valid        = out_valid_q;
    assign bus.fault            = fault_q;

endmodule

`default_nettype wire
